// File: rtl/prio_encoder8_if.sv
// prio_encoder8 output handshake bundle
// master drives code/valid, slave drives ready
interface prio_encoder8_if;
  logic [2:0] code;
  logic       valid;
  logic       ready;

  modport master (
    output code,
    output valid,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    output ready
  );
endinterface

// File: rtl/prio_encoder8.sv
// Registered 8-to-3 priority encoder / request serializer
// Optional merged-request counter: PRIO_ENC_DROP_CNT_EN
module prio_encoder8 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            req,
  prio_encoder8_if.master       out,
  output logic                  busy
`ifdef PRIO_ENC_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] eff;
  logic       load;

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) r = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++)
        if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next pending set and output register contents
  always_comb begin
    eff     = pend_q | req;
    load    = !valid_q || out.ready;
    pend_d  = eff;
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      if (|eff) begin
        code_d  = enc(eff);
        valid_d = 1'b1;
        pend_d  = eff & ~(8'd1 << code_d);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Pending and presented request state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign out.code  = code_q;
  assign out.valid = valid_q;
  assign busy      = valid_q | (|pend_q);

`ifdef PRIO_ENC_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic [3:0] hits;
  logic [8:0] sum;

  // Count req bits folding into an already pending bit, saturating
  always_comb begin
    hits = '0;
    for (int i = 0; i < 8; i++)
      hits = hits + {3'b0, req[i] & pend_q[i]};
    sum    = {1'b0, drop_q} + {5'b0, hits};
    drop_d = sum[8] ? 8'hFF : sum[7:0];
  end

  // Merge counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule
